// File: rtl/custom_pkg.sv
// rtl/custom_pkg.sv - shared types and constants for the custom instruction dispatcher
package custom_pkg;

    // Custom ops the vector engine understands; anything else is answered with 0.
    typedef enum logic [4:0] {
        OP_ADD = 5'd3,
        OP_EQU = 5'd5,
        OP_MOD = 5'd6
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_WB
    } state_e;

    // Owner of the single RAM port in a given cycle.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_LSU,
        SEL_ENG_RD,
        SEL_ENG_WR
    } ram_sel_e;

    localparam logic [31:0] ERR_RESULT = 32'hFFFF_FFFF;

    function automatic logic is_legal_op(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_EQU) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/custom_dispatch_if.sv
// rtl/custom_dispatch_if.sv - core-side instruction/writeback and LSU bus of the dispatcher
// Signal names keep the dispatcher's point of view (_i into it, _o out of it).
//   master : core/LSU side   slave : custom_dispatch
interface custom_dispatch_if #(
    parameter int ADDR_W = 14
) ();
    logic              instr_valid_i;
    logic [4:0]        instr_op_i;
    logic [31:0]       op_a_i;
    logic [31:0]       op_b_i;
    logic              instr_ready_o;
    logic              wb_valid_o;
    logic [31:0]       wb_data_o;

    logic              lsu_req_i;
    logic              lsu_we_i;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic [31:0]       lsu_wdata_i;
    logic              lsu_gnt_o;
    logic              lsu_rvalid_o;
    logic [31:0]       lsu_rdata_o;

    modport master (
        output instr_valid_i, instr_op_i, op_a_i, op_b_i,
        input  instr_ready_o, wb_valid_o, wb_data_o,
        output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i,
        input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o
    );

    modport slave (
        input  instr_valid_i, instr_op_i, op_a_i, op_b_i,
        output instr_ready_o, wb_valid_o, wb_data_o,
        input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i,
        output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o
    );
endinterface

// File: rtl/custom_ram_mux.sv
// rtl/custom_ram_mux.sv - RAM port select between LSU, engine read and engine write-back
// Ports: sel_i picks the owner; lsu_*/eng_addr_i/wr_* are the candidate requests;
//        ram_* drive the RAM; lsu_rvalid_o flags LSU read data one cycle after a granted read.
module custom_ram_mux
    import custom_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  ram_sel_e          sel_i,
    input  logic              lsu_we_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [31:0]       lsu_wdata_i,
    input  logic [ADDR_W-1:0] eng_addr_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [31:0]       wr_data_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [31:0]       ram_wdata_o,
    output logic              lsu_rvalid_o
);

    logic rvalid_d, rvalid_q;

    always_comb begin
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_wdata_o = '0;
        case (sel_i)
            SEL_LSU: begin
                ram_addr_o  = lsu_addr_i;
                ram_we_o    = lsu_we_i;
                ram_wdata_o = lsu_wdata_i;
            end
            SEL_ENG_RD: ram_addr_o = eng_addr_i;
            SEL_ENG_WR: begin
                ram_addr_o  = wr_addr_i;
                ram_we_o    = 1'b1;
                ram_wdata_o = wr_data_i;
            end
            default: ;
        endcase
    end

    // RAM read latency is one cycle, so a granted LSU read returns on the next one.
    always_comb rvalid_d = (sel_i == SEL_LSU) && !lsu_we_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rvalid_q <= 1'b0;
        else     rvalid_q <= rvalid_d;
    end

    assign lsu_rvalid_o = rvalid_q;

endmodule

// File: rtl/custom_dispatch.sv
// rtl/custom_dispatch.sv - custom instruction sequencer and data-RAM port arbiter
// Ports: core (custom_dispatch_if.slave) carries instruction accept/writeback and LSU access;
//        custom_* / array*_addr_o / eng_ram_* talk to the vector engine; ram_* is the single RAM port.
module custom_dispatch
    import custom_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    custom_dispatch_if.slave  core,
    output logic              custom_en_o,
    output logic [4:0]        custom_op_o,
    output logic [31:0]       array1_addr_o,
    output logic [31:0]       array2_addr_o,
    input  logic              custom_final_i,
    input  logic [31:0]       custom_result_i,
    input  logic              custom_valid_i,
    input  logic [31:0]       custom_data_i,
    input  logic [ADDR_W-1:0] eng_ram_addr_i,
    output logic [31:0]       eng_ram_data_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    state_e            state_d, state_q;
    logic [4:0]        op_d, op_q;
    logic [31:0]       a_d, a_q;
    logic [31:0]       b_d, b_q;
    logic [ADDR_W-1:0] base_d, base_q;
    logic [ADDR_W-1:0] wcnt_d, wcnt_q;
    logic [TW-1:0]     tcnt_d, tcnt_q;
    logic [31:0]       result_d, result_q;

    logic     ready, en, wbv, gnt;
    ram_sel_e sel, sel_gated;
    logic     lsu_rvalid;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        base_d   = base_q;
        wcnt_d   = wcnt_q;
        tcnt_d   = tcnt_q;
        result_d = result_q;
        ready    = 1'b0;
        en       = 1'b0;
        wbv      = 1'b0;
        gnt      = 1'b0;
        sel      = SEL_NONE;
        case (state_q)
            S_IDLE: begin
                gnt = core.lsu_req_i;
                sel = core.lsu_req_i ? SEL_LSU : SEL_NONE;
                if (core.instr_valid_i) begin
                    ready = 1'b1;
                    if (is_legal_op(core.instr_op_i)) begin
                        op_d    = core.instr_op_i;
                        a_d     = core.op_a_i;
                        b_d     = core.op_b_i;
                        // Engine output lands at array1, converted from byte to word address.
                        base_d  = core.op_a_i[ADDR_W+1:2];
                        wcnt_d  = '0;
                        state_d = S_LAUNCH;
                    end else begin
                        result_d = '0;
                        state_d  = S_WB;
                    end
                end
            end
            S_LAUNCH: begin
                en      = 1'b1;
                sel     = SEL_ENG_RD;
                tcnt_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                sel    = SEL_ENG_RD;
                tcnt_d = tcnt_q + TW'(1);
                // An output word beats the engine's own read for the port this cycle.
                if (custom_valid_i) begin
                    sel    = SEL_ENG_WR;
                    wcnt_d = wcnt_q + ADDR_W'(1);
                end
                if (custom_final_i) begin
                    result_d = custom_result_i;
                    state_d  = S_DRAIN;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    result_d = ERR_RESULT;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                sel     = SEL_ENG_RD;
                state_d = S_WB;
            end
            S_WB: begin
                wbv     = 1'b1;
                sel     = SEL_ENG_RD;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            base_q   <= '0;
            wcnt_q   <= '0;
            tcnt_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            base_q   <= base_d;
            wcnt_q   <= wcnt_d;
            tcnt_q   <= tcnt_d;
            result_q <= result_d;
        end
    end

    // Combinational outputs are forced quiet while reset is held, since IDLE
    // would otherwise pass LSU/instruction inputs straight through.
    assign sel_gated = rst ? SEL_NONE : sel;

    custom_ram_mux #(.ADDR_W(ADDR_W)) u_ram_mux (
        .clk          (clk),
        .rst          (rst),
        .sel_i        (sel_gated),
        .lsu_we_i     (core.lsu_we_i),
        .lsu_addr_i   (core.lsu_addr_i),
        .lsu_wdata_i  (core.lsu_wdata_i),
        .eng_addr_i   (eng_ram_addr_i),
        .wr_addr_i    (base_q + wcnt_q),
        .wr_data_i    (custom_data_i),
        .ram_addr_o   (ram_addr_o),
        .ram_we_o     (ram_we_o),
        .ram_wdata_o  (ram_wdata_o),
        .lsu_rvalid_o (lsu_rvalid)
    );

    assign core.instr_ready_o = ready & ~rst;
    assign core.wb_valid_o    = wbv & ~rst;
    assign core.wb_data_o     = result_q;
    assign core.lsu_gnt_o     = gnt & ~rst;
    assign core.lsu_rvalid_o  = lsu_rvalid;
    assign core.lsu_rdata_o   = ram_rdata_i;

    assign custom_en_o    = en & ~rst;
    assign custom_op_o    = op_q;
    assign array1_addr_o  = a_q;
    assign array2_addr_o  = b_q;
    assign eng_ram_data_o = ram_rdata_i;

endmodule

// File: tb/tb_custom_dispatch.sv
// tb/tb_custom_dispatch.sv - directed self-checking bench for custom_dispatch
module tb_custom_dispatch;

    localparam int ADDR_W = 14;

    logic              clk;
    logic              rst;
    logic              custom_en;
    logic [4:0]        custom_op;
    logic [31:0]       array1_addr;
    logic [31:0]       array2_addr;
    logic              custom_final;
    logic [31:0]       custom_result;
    logic              custom_valid;
    logic [31:0]       custom_data;
    logic [ADDR_W-1:0] eng_ram_addr;
    logic [31:0]       eng_ram_data;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    custom_dispatch_if #(.ADDR_W(ADDR_W)) bus ();

    custom_dispatch #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .core            (bus),
        .custom_en_o     (custom_en),
        .custom_op_o     (custom_op),
        .array1_addr_o   (array1_addr),
        .array2_addr_o   (array2_addr),
        .custom_final_i  (custom_final),
        .custom_result_i (custom_result),
        .custom_valid_i  (custom_valid),
        .custom_data_i   (custom_data),
        .eng_ram_addr_i  (eng_ram_addr),
        .eng_ram_data_o  (eng_ram_data),
        .ram_addr_o      (ram_addr),
        .ram_we_o        (ram_we),
        .ram_wdata_o     (ram_wdata),
        .ram_rdata_i     (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.instr_valid_i = 1'b1;
        bus.instr_op_i    = 5'd3;
        bus.op_a_i        = 32'h0;
        bus.op_b_i        = 32'h0;
        bus.lsu_req_i     = 1'b1;
        bus.lsu_we_i      = 1'b0;
        bus.lsu_addr_i    = '0;
        bus.lsu_wdata_i   = 32'h0;
        custom_final  = 1'b0;
        custom_result = 32'h0;
        custom_valid  = 1'b0;
        custom_data   = 32'h0;
        eng_ram_addr  = '0;

        // Reset: every control output held low even with requests present.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", bus.lsu_gnt_o, 0);
        chk("rst_ready", bus.instr_ready_o, 0);
        chk("rst_en", custom_en, 0);
        chk("rst_wbv", bus.wb_valid_o, 0);
        chk("rst_wbd", bus.wb_data_o, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_rvalid", bus.lsu_rvalid_o, 0);
        bus.instr_valid_i = 1'b0;
        bus.lsu_req_i     = 1'b0;
        rst = 1'b0;
        tick();

        // LSU write then read in IDLE.
        bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b1; bus.lsu_addr_i = 14'd10; bus.lsu_wdata_i = 32'hA5;
        #1;
        chk("lsu_wr_gnt", bus.lsu_gnt_o, 1);
        chk("lsu_wr_we", ram_we, 1);
        chk("lsu_wr_addr", ram_addr, 10);
        tick();
        bus.lsu_we_i = 1'b0;
        #1;
        chk("lsu_rd_gnt", bus.lsu_gnt_o, 1);
        chk("lsu_rd_we", ram_we, 0);
        chk("lsu_rvalid_after_wr", bus.lsu_rvalid_o, 0);
        tick();
        bus.lsu_req_i = 1'b0;
        #1;
        chk("lsu_rvalid", bus.lsu_rvalid_o, 1);
        chk("lsu_rdata", bus.lsu_rdata_o, 32'hA5);
        tick();
        chk("lsu_rvalid_drop", bus.lsu_rvalid_o, 0);

        // Add op: three output words then final; LSU read request held across the run.
        bus.instr_valid_i = 1'b1; bus.instr_op_i = 5'd3; bus.op_a_i = 32'h100; bus.op_b_i = 32'h200;
        #1;
        chk("add_ready", bus.instr_ready_o, 1);
        tick();
        bus.instr_valid_i = 1'b0;
        #1;
        chk("add_en", custom_en, 1);
        chk("add_op", custom_op, 3);
        chk("add_a", array1_addr, 32'h100);
        chk("add_b", array2_addr, 32'h200);
        chk("add_ready_launch", bus.instr_ready_o, 0);
        tick();
        chk("add_en_pulse", custom_en, 0);
        bus.lsu_req_i = 1'b1; bus.lsu_we_i = 1'b0; bus.lsu_addr_i = 14'd10;
        for (int i = 0; i < 3; i++) begin
            custom_valid = 1'b1;
            custom_data  = 32'(i + 1);
            #1;
            chk("add_wr_we", ram_we, 1);
            chk("add_wr_addr", ram_addr, 32'h40 + 32'(i));
            chk("add_wr_data", ram_wdata, 32'(i + 1));
            chk("run_gnt", bus.lsu_gnt_o, 0);
            tick();
        end
        custom_valid = 1'b0;
        eng_ram_addr = 14'h40;
        #1;
        chk("eng_rd_addr", ram_addr, 32'h40);
        chk("eng_rd_we", ram_we, 0);
        tick();
        chk("eng_rd_data", eng_ram_data, 1);
        custom_final = 1'b1; custom_result = 32'h100;
        #1;
        chk("fin_wbv0", bus.wb_valid_o, 0);
        tick();
        custom_final = 1'b0;
        chk("drain_wbv", bus.wb_valid_o, 0);
        chk("drain_gnt", bus.lsu_gnt_o, 0);
        tick();
        chk("wb_valid", bus.wb_valid_o, 1);
        chk("wb_data", bus.wb_data_o, 32'h100);
        chk("wb_gnt", bus.lsu_gnt_o, 0);
        tick();
        chk("wb_pulse", bus.wb_valid_o, 0);
        chk("idle_gnt", bus.lsu_gnt_o, 1);
        chk("mem40", mem[14'h40], 1);
        chk("mem41", mem[14'h41], 2);
        chk("mem42", mem[14'h42], 3);
        tick();
        bus.lsu_req_i = 1'b0;
        chk("held_rvalid", bus.lsu_rvalid_o, 1);
        chk("held_rdata", bus.lsu_rdata_o, 32'hA5);

        // Final outside RUN is ignored.
        custom_final = 1'b1; custom_result = 32'h55;
        tick();
        tick();
        custom_final = 1'b0;
        chk("stray_final_wbv", bus.wb_valid_o, 0);
        chk("stray_final_en", custom_en, 0);

        // Illegal op: straight to writeback of 0, then back-to-back accept only after WB.
        bus.instr_valid_i = 1'b1; bus.instr_op_i = 5'd7;
        #1;
        chk("ill_ready", bus.instr_ready_o, 1);
        tick();
        chk("ill_en", custom_en, 0);
        chk("ill_wbv", bus.wb_valid_o, 1);
        chk("ill_wbd", bus.wb_data_o, 0);
        chk("ill_ready_wb", bus.instr_ready_o, 0);
        tick();
        chk("b2b_ready", bus.instr_ready_o, 1);
        chk("b2b_wbv", bus.wb_valid_o, 0);
        tick();
        bus.instr_valid_i = 1'b0;
        chk("b2b_wbv2", bus.wb_valid_o, 1);
        tick();

        // Timeout with wrapping write address: base = 0x3FFF.
        bus.instr_valid_i = 1'b1; bus.instr_op_i = 5'd6; bus.op_a_i = 32'h0000_FFFC; bus.op_b_i = 32'd7;
        tick();
        bus.instr_valid_i = 1'b0;
        chk("to_en", custom_en, 1);
        tick();
        custom_valid = 1'b1; custom_data = 32'hAA;
        #1;
        chk("wrap_addr0", ram_addr, 32'h3FFF);
        tick();
        custom_data = 32'hBB;
        #1;
        chk("wrap_addr1", ram_addr, 32'h0000);
        tick();
        custom_valid = 1'b0;
        for (int i = 3; i < 17; i++) tick();
        chk("to_wbv_early", bus.wb_valid_o, 0);
        tick();
        chk("to_wbv", bus.wb_valid_o, 1);
        chk("to_wbd", bus.wb_data_o, 32'hFFFF_FFFF);
        tick();

        // Reset in the middle of RUN.
        bus.instr_valid_i = 1'b1; bus.instr_op_i = 5'd5; bus.op_a_i = 32'h200; bus.op_b_i = 32'h3;
        tick();
        bus.instr_valid_i = 1'b0;
        tick();
        custom_valid = 1'b1; custom_data = 32'h5; bus.lsu_req_i = 1'b1;
        #1;
        chk("mid_we", ram_we, 1);
        rst = 1'b1;
        #1;
        chk("arst_we", ram_we, 0);
        chk("arst_en", custom_en, 0);
        chk("arst_gnt", bus.lsu_gnt_o, 0);
        chk("arst_op", custom_op, 0);
        chk("arst_a", array1_addr, 0);
        chk("arst_wbd", bus.wb_data_o, 0);
        tick();
        custom_valid = 1'b0; bus.lsu_req_i = 1'b0;
        rst = 1'b0;
        tick();
        chk("arst_no_wb", bus.wb_valid_o, 0);

        // Normal operation afterwards.
        bus.instr_valid_i = 1'b1; bus.instr_op_i = 5'd5; bus.op_a_i = 32'h80; bus.op_b_i = 32'h0;
        #1;
        chk("post_ready", bus.instr_ready_o, 1);
        tick();
        bus.instr_valid_i = 1'b0;
        chk("post_en", custom_en, 1);
        tick();
        custom_valid = 1'b1; custom_final = 1'b1; custom_data = 32'h77; custom_result = 32'h1234;
        #1;
        chk("post_wr_addr", ram_addr, 32'h20);
        tick();
        custom_valid = 1'b0; custom_final = 1'b0;
        tick();
        chk("post_wbv", bus.wb_valid_o, 1);
        chk("post_wbd", bus.wb_data_o, 32'h1234);
        chk("post_mem", mem[14'h20], 32'h77);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/custom_dispatch.md
# custom_dispatch

Sequencing and sharing controller for the custom vector engine: accepts decoded custom instructions (op 5 bits, operand_a/operand_b) from the core, launches the engine, stalls the core until completion, and returns the result address to writeback. Also owns the single data-RAM port, sharing it between the core LSU and the engine. The port is granted to the engine while it runs, and the engine's `custom_valid`/`custom_data` output words are written back into RAM.

## Interface
Parameters:
- `ADDR_W`, 14: RAM word-address width.
- `TIMEOUT`, 1024: maximum engine cycles before abort.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `instr_valid_i` in 1: custom instruction present.
- `instr_op_i` in 5: custom op.
- `op_a_i` in 32: operand_a, array1 byte address.
- `op_b_i` in 32: operand_b, array2 byte address or modulus.
- `instr_ready_o` out 1: instruction accepted; core stalls while low.
- `wb_valid_o` out 1: one-cycle writeback strobe.
- `wb_data_o` out 32: writeback value.
- `custom_en_o` out 1: engine launch.
- `custom_op_o` out 5: op to engine.
- `array1_addr_o` out 32: operand_a to engine.
- `array2_addr_o` out 32: operand_b to engine.
- `custom_final_i` in 1: engine done.
- `custom_result_i` in 32: engine result address.
- `custom_valid_i` in 1: engine output word valid.
- `custom_data_i` in 32: engine output word.
- `eng_ram_addr_i` in ADDR_W: engine read address.
- `eng_ram_data_o` out 32: RAM read data to engine.
- `lsu_req_i` in 1: LSU access request.
- `lsu_we_i` in 1: LSU write.
- `lsu_addr_i` in ADDR_W: LSU word address.
- `lsu_wdata_i` in 32: LSU write data.
- `lsu_gnt_o` out 1: LSU request granted.
- `lsu_rvalid_o` out 1: LSU read data valid.
- `lsu_rdata_o` out 32: LSU read data.
- `ram_addr_o` out ADDR_W: RAM address.
- `ram_we_o` out 1: RAM write enable.
- `ram_wdata_o` out 32: RAM write data.
- `ram_rdata_i` in 32: RAM read data, synchronous, 1-cycle latency.

## Operation
- FSM states: IDLE, LAUNCH, RUN, DRAIN, WB.
- **IDLE:** `lsu_gnt_o = lsu_req_i`; RAM driven from LSU.
  - On `instr_valid_i` with a legal op (3 add, 5 equ, 6 mod): latch op/operands, capture `wcnt=0` and `base = op_a_i[ADDR_W+1:2]`, pulse `instr_ready_o`, go to LAUNCH.
  - Illegal op: pulse `instr_ready_o`, go to WB with `wb_data_o=0`; engine is not launched.
- **LAUNCH:** assert `custom_en_o` for exactly 1 cycle, clear the timeout counter, go to RUN.
- **RUN:** `lsu_gnt_o=0`; `ram_addr_o=eng_ram_addr_i`, `ram_we_o=0`.
  - If `custom_valid_i`: `ram_we_o=1`, `ram_addr_o=base+wcnt` (mod 2^ADDR_W, wraps), `ram_wdata_o=custom_data_i`, then `wcnt++`. The write wins over the engine read that cycle.
  - `custom_final_i`: latch `custom_result_i`, go to DRAIN.
  - Timeout counter reaching TIMEOUT-1: latch `32'hFFFF_FFFF`, go to DRAIN.
- **DRAIN:** one cycle; LSU still blocked, so the engine's Finalize_2 clear completes. Go to WB.
- **WB:** `wb_valid_o=1` for 1 cycle with the latched value, then IDLE.
- `eng_ram_data_o = ram_rdata_i` always.
- `lsu_rdata_o = ram_rdata_i`; `lsu_rvalid_o` asserts 1 cycle after a granted read.
- `custom_final_i` arriving outside RUN is ignored.
- `custom_valid_i` and `custom_final_i` in the same cycle: the write is performed and the FSM still moves to DRAIN.

## Timing
- Reset values: all outputs 0, FSM IDLE, counters 0. Reset mid-RUN aborts immediately with no writeback; the engine sees `custom_en_o=0`.
- `instr_ready_o` rises in the same cycle as `instr_valid_i` in IDLE (combinational from state and valid), else 0.
- Latency: accept → `custom_en_o` 1 cycle; `custom_final_i` → `wb_valid_o` 2 cycles (DRAIN, WB).
- Back-to-back instructions: the earliest accept is the cycle after WB.
- An LSU request held across RUN is granted in the first IDLE cycle.

## Structure
- Package `custom_pkg`: op enum (`OP_ADD=5'd3`, `OP_EQU=5'd5`, `OP_MOD=5'd6`), FSM state typedef, `ERR_RESULT=32'hFFFF_FFFF`.
- Sub-module `custom_ram_mux`: combinational RAM port select (LSU/engine-read/engine-write) plus the rvalid register.

## Test plan
- LSU-only in IDLE: write 0xA5 to addr 10, then read → `lsu_gnt_o=1` both times, `lsu_rvalid_o` next cycle with data 0xA5.
- Add op 3, `op_a`=0x100: engine returns 3 valid words 1,2,3, then final with 0x100 → RAM[0x40..0x42]=1,2,3, `wb_data_o`=0x100 two cycles after final.
- LSU request during RUN → `lsu_gnt_o=0` until the first IDLE cycle, then granted.
- Op 5'd7 → no `custom_en_o`; `wb_valid_o` with 0 after 1 cycle.
- Engine never finals, TIMEOUT=16 → `wb_data_o`=0xFFFFFFFF at cycle 16+2 after launch.
- Reset asserted mid-RUN → all outputs 0 asynchronously; a subsequent instruction completes normally.
